// File: rtl/cv32e40s_pkg.sv
// Shared types for the CLIC interrupt controller: privilege levels, CSR views,
// controller FSM states and the NLBITS level normalisation helper.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  typedef struct packed {
    logic [7:0] mil;
    logic [7:0] sil;
    logic [7:0] uil;
  } mintstatus_t;

  typedef struct packed {
    logic        irq;
    logic        minhv;
    logic [7:0]  mpil;
    logic [10:0] exccode;
  } mcause_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    ACK  = 2'b10,
    DROP = 2'b11
  } clic_ctrl_state_e;

  // Keep the nlbits most significant bits of the level; the rest read as 1.
  function automatic logic [7:0] clic_norm_level(input logic [7:0] level, input int nlbits);
    logic [7:0] norm;
    for (int i = 0; i < 8; i++) begin
      norm[i] = (i < 8 - nlbits) ? 1'b1 : level[i];
    end
    return norm;
  endfunction

endpackage

// File: rtl/cv32e40s_clic_lvl_cmp.sv
// Privilege/threshold qualifier for a normalised CLIC level.
// U-mode target handling exists only with CV32E40S_CLIC_UMODE_IRQ_EN defined.
module cv32e40s_clic_lvl_cmp
  import cv32e40s_pkg::*;
(
  input  logic [7:0] level,
  input  privlvl_t   target_priv,
  input  privlvl_t   cur_priv,
  input  logic [7:0] mintthresh,
  input  logic [7:0] mil,
`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
  input  logic [7:0] uintthresh,
  input  logic [7:0] uil,
`endif
  output logic       lvl_ok
);

  logic [7:0] max_m;
  assign max_m = (mintthresh > mil) ? mintthresh : mil;

`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
  logic [7:0] max_u;
  assign max_u = (uintthresh > uil) ? uintthresh : uil;
`endif

  always_comb begin
    lvl_ok = 1'b0;
    if ((target_priv == PRIV_LVL_M) && (cur_priv == PRIV_LVL_M)) begin
      lvl_ok = level > max_m;
    end else if (target_priv > cur_priv) begin
      // Higher-privilege target preempts regardless of thresholds.
      lvl_ok = level != 8'h00;
`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
    end else if ((target_priv == PRIV_LVL_U) && (cur_priv == PRIV_LVL_U)) begin
      lvl_ok = level > max_u;
`endif
    end
  end

endmodule

// File: rtl/cv32e40s_clic_int_controller_mp.sv
// CLIC interrupt controller: captures the CLIC request, qualifies it against
// privilege/thresholds, handshakes with the core and waits for the CLIC to retire
// acked IDs. Optional U-mode targets: CV32E40S_CLIC_UMODE_IRQ_EN.
module cv32e40s_clic_int_controller_mp
  import cv32e40s_pkg::*;
#(
  parameter int CLIC_ID_WIDTH   = 5,
  parameter int CLIC_LEVEL_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clic_irq_i,
  input  logic [CLIC_ID_WIDTH-1:0] clic_irq_id_i,
  input  logic [7:0]               clic_irq_level_i,
  input  logic [1:0]               clic_irq_priv_i,
  input  logic                     clic_irq_shv_i,
  output logic                     clic_irq_ack_o,
  output logic [CLIC_ID_WIDTH-1:0] clic_irq_ack_id_o,
  output logic                     irq_req_ctrl_o,
  input  logic                     irq_ack_i,
  output logic [9:0]               irq_id_ctrl_o,
  output logic                     irq_wu_ctrl_o,
  output logic                     irq_clic_shv_o,
  output logic [7:0]               irq_clic_level_o,
  output privlvl_t                 irq_clic_priv_o,
  input  mstatus_t                 mstatus_i,
  input  mintstatus_t              mintstatus_i,
  input  mcause_t                  mcause_i,
  input  privlvl_t                 priv_lvl_i,
  input  logic [7:0]               mintthresh_th_i,
  input  logic [7:0]               uintthresh_th_i,
  output logic                     mnxti_irq_pending_o,
  output logic [CLIC_ID_WIDTH-1:0] mnxti_irq_id_o,
  output logic [7:0]               mnxti_irq_level_o
);

  // Handshake: irq_req_ctrl_o is the valid, irq_ack_i the ready; a transfer
  // happens on a clock edge where both are high. The controller then pulses
  // clic_irq_ack_o for one cycle with the transferred (flopped) ID.

  clic_ctrl_state_e         state_q, state_d;
  logic [CLIC_ID_WIDTH-1:0] id_q;
  logic [7:0]               level_q;
  privlvl_t                 priv_q;
  logic                     shv_q;
  logic                     capture;

  logic [7:0] raw_level;
  privlvl_t   raw_priv;
  logic       lvl_ok_q;
  logic       lvl_ok_raw;
  logic       gie;
  logic       in_pend;
  logic       same_as_acked;

  assign raw_level = clic_norm_level(clic_irq_level_i, CLIC_LEVEL_BITS);

`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
  assign raw_priv = (clic_irq_priv_i == 2'b00) ? PRIV_LVL_U : PRIV_LVL_M;
`else
  assign raw_priv = PRIV_LVL_M;
`endif

  assign in_pend       = (state_q == PEND);
  assign same_as_acked = (state_q == DROP) && clic_irq_i && (clic_irq_id_i == id_q);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (clic_irq_i) begin
          capture = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        // A controller ack beats a simultaneous CLIC replacement.
        if (irq_ack_i && irq_req_ctrl_o) begin
          state_d = ACK;
        end else if (clic_irq_i) begin
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = DROP;
      end
      DROP: begin
        if (!same_as_acked) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      level_q <= 8'h00;
      priv_q  <= PRIV_LVL_M;
      shv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        id_q    <= clic_irq_id_i;
        level_q <= raw_level;
        priv_q  <= raw_priv;
        shv_q   <= clic_irq_shv_i;
      end
    end
  end

  cv32e40s_clic_lvl_cmp u_lvl_cmp_q (
    .level       (level_q),
    .target_priv (priv_q),
    .cur_priv    (priv_lvl_i),
    .mintthresh  (mintthresh_th_i),
    .mil         (mintstatus_i.mil),
`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
    .uintthresh  (uintthresh_th_i),
    .uil         (mintstatus_i.uil),
`endif
    .lvl_ok      (lvl_ok_q)
  );

  // Wakeup must work with the clock gated, so it looks at the raw inputs.
  cv32e40s_clic_lvl_cmp u_lvl_cmp_raw (
    .level       (raw_level),
    .target_priv (raw_priv),
    .cur_priv    (priv_lvl_i),
    .mintthresh  (mintthresh_th_i),
    .mil         (mintstatus_i.mil),
`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
    .uintthresh  (uintthresh_th_i),
    .uil         (mintstatus_i.uil),
`endif
    .lvl_ok      (lvl_ok_raw)
  );

  assign gie = mstatus_i.mie || (priv_lvl_i < priv_q);

  assign irq_req_ctrl_o    = in_pend && gie && lvl_ok_q;
  assign clic_irq_ack_o    = (state_q == ACK);
  assign clic_irq_ack_id_o = (state_q == ACK) ? id_q : '0;
  assign irq_id_ctrl_o     = 10'(id_q);
  assign irq_wu_ctrl_o     = clic_irq_i && lvl_ok_raw && !same_as_acked;
  assign irq_clic_shv_o    = shv_q;
  assign irq_clic_level_o  = level_q;
  assign irq_clic_priv_o   = priv_q;

  assign mnxti_irq_pending_o = in_pend && (level_q > mcause_i.mpil) && (level_q > mintthresh_th_i) &&
                               !shv_q && (priv_q == PRIV_LVL_M);
  assign mnxti_irq_id_o      = id_q;
  assign mnxti_irq_level_o   = level_q;

  logic unused_inputs;
`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
  assign unused_inputs = ^{mstatus_i.mpie, mintstatus_i.sil, mcause_i.irq, mcause_i.minhv,
                           mcause_i.exccode};
`else
  assign unused_inputs = ^{mstatus_i.mpie, mintstatus_i.sil, mcause_i.irq, mcause_i.minhv,
                           mcause_i.exccode, clic_irq_priv_i, uintthresh_th_i, mintstatus_i.uil};
`endif

`ifndef SYNTHESIS
  ack_needs_req: assert property (@(posedge clk) disable iff (rst) irq_ack_i |-> irq_req_ctrl_o);
`endif

endmodule

// File: tb/tb_cv32e40s_clic_int_controller_mp.sv
// Scoreboarded bench for cv32e40s_clic_int_controller_mp (IDW=5, NLBITS=3).
module tb_cv32e40s_clic_int_controller_mp;
  import cv32e40s_pkg::*;

  localparam int IDW = 5;

  logic           clk;
  logic           rst;
  logic           clic_irq_i;
  logic [IDW-1:0] clic_irq_id_i;
  logic [7:0]     clic_irq_level_i;
  logic [1:0]     clic_irq_priv_i;
  logic           clic_irq_shv_i;
  logic           clic_irq_ack_o;
  logic [IDW-1:0] clic_irq_ack_id_o;
  logic           irq_req_ctrl_o;
  logic           irq_ack_i;
  logic [9:0]     irq_id_ctrl_o;
  logic           irq_wu_ctrl_o;
  logic           irq_clic_shv_o;
  logic [7:0]     irq_clic_level_o;
  privlvl_t       irq_clic_priv_o;
  mstatus_t       mstatus_i;
  mintstatus_t    mintstatus_i;
  mcause_t        mcause_i;
  privlvl_t       priv_lvl_i;
  logic [7:0]     mintthresh_th_i;
  logic [7:0]     uintthresh_th_i;
  logic           mnxti_irq_pending_o;
  logic [IDW-1:0] mnxti_irq_id_o;
  logic [7:0]     mnxti_irq_level_o;

  cv32e40s_clic_int_controller_mp #(
    .CLIC_ID_WIDTH   (IDW),
    .CLIC_LEVEL_BITS (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .clic_irq_i          (clic_irq_i),
    .clic_irq_id_i       (clic_irq_id_i),
    .clic_irq_level_i    (clic_irq_level_i),
    .clic_irq_priv_i     (clic_irq_priv_i),
    .clic_irq_shv_i      (clic_irq_shv_i),
    .clic_irq_ack_o      (clic_irq_ack_o),
    .clic_irq_ack_id_o   (clic_irq_ack_id_o),
    .irq_req_ctrl_o      (irq_req_ctrl_o),
    .irq_ack_i           (irq_ack_i),
    .irq_id_ctrl_o       (irq_id_ctrl_o),
    .irq_wu_ctrl_o       (irq_wu_ctrl_o),
    .irq_clic_shv_o      (irq_clic_shv_o),
    .irq_clic_level_o    (irq_clic_level_o),
    .irq_clic_priv_o     (irq_clic_priv_o),
    .mstatus_i           (mstatus_i),
    .mintstatus_i        (mintstatus_i),
    .mcause_i            (mcause_i),
    .priv_lvl_i          (priv_lvl_i),
    .mintthresh_th_i     (mintthresh_th_i),
    .uintthresh_th_i     (uintthresh_th_i),
    .mnxti_irq_pending_o (mnxti_irq_pending_o),
    .mnxti_irq_id_o      (mnxti_irq_id_o),
    .mnxti_irq_level_o   (mnxti_irq_level_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // {cycle[15:0], id[4:0], level[7:0]} and {cycle[15:0], id[4:0]}
  logic [28:0] exp_req_q[$];
  logic [20:0] exp_ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int at, input logic [4:0] id, input logic [7:0] lvl);
    logic [15:0] c;
    c = 16'(at);
    exp_req_q.push_back({c, id, lvl});
  endtask

  task automatic push_ack(input int at, input logic [4:0] id);
    logic [15:0] c;
    c = 16'(at);
    exp_ack_q.push_back({c, id});
  endtask

  // Monitor: a request event is req high with a newly presented id/level.
  initial begin
    logic       prev_req;
    logic [9:0] prev_id;
    logic [7:0] prev_lvl;
    logic [28:0] er;
    logic [20:0] ea;
    prev_req = 1'b0;
    prev_id  = '0;
    prev_lvl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (irq_req_ctrl_o && !(prev_req && irq_id_ctrl_o == prev_id && irq_clic_level_o == prev_lvl)) begin
          if (exp_req_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_req: got id=%0d level=0x%0h, expected no request (cycle %0d)",
                     irq_id_ctrl_o, irq_clic_level_o, cyc);
          end else begin
            er = exp_req_q.pop_front();
            check("req_id", 32'(irq_id_ctrl_o), 32'(er[12:8]));
            check("req_level", 32'(irq_clic_level_o), 32'(er[7:0]));
            check("req_cycle", 32'(cyc[15:0]), 32'(er[28:13]));
          end
        end
        if (clic_irq_ack_o) begin
          if (exp_ack_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack: got id=%0d, expected no ack (cycle %0d)", clic_irq_ack_id_o, cyc);
          end else begin
            ea = exp_ack_q.pop_front();
            check("ack_id", 32'(clic_irq_ack_id_o), 32'(ea[4:0]));
            check("ack_cycle", 32'(cyc[15:0]), 32'(ea[20:5]));
          end
        end
        prev_req = irq_req_ctrl_o;
        prev_id  = irq_id_ctrl_o;
        prev_lvl = irq_clic_level_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!irq_req_ctrl_o && n < 10) begin
      tick();
      n++;
    end
    check(name, 32'(irq_req_ctrl_o), 32'd1);
  endtask

  task automatic present(input logic [4:0] id, input logic [7:0] lvl);
    clic_irq_i       = 1'b1;
    clic_irq_id_i    = id;
    clic_irq_level_i = lvl;
  endtask

  task automatic ack_req();
    irq_ack_i = 1'b1;
    push_ack(cyc + 1, 5'(irq_id_ctrl_o));
    tick();
    irq_ack_i = 1'b0;
  endtask

  task automatic release_irq();
    clic_irq_i = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    clic_irq_i       = 1'b0;
    clic_irq_id_i    = '0;
    clic_irq_level_i = 8'h00;
    clic_irq_priv_i  = 2'b11;
    clic_irq_shv_i   = 1'b0;
    irq_ack_i        = 1'b0;
    mstatus_i        = '{mpie: 1'b0, mie: 1'b1};
    mintstatus_i     = '0;
    mcause_i         = '0;
    priv_lvl_i       = PRIV_LVL_M;
    mintthresh_th_i  = 8'h40;
    uintthresh_th_i  = 8'h00;

    repeat (3) tick();
    check("rst_ack", 32'(clic_irq_ack_o), 32'd0);
    check("rst_ack_id", 32'(clic_irq_ack_id_o), 32'd0);
    check("rst_req", 32'(irq_req_ctrl_o), 32'd0);
    check("rst_id", 32'(irq_id_ctrl_o), 32'd0);
    check("rst_wu", 32'(irq_wu_ctrl_o), 32'd0);
    check("rst_shv", 32'(irq_clic_shv_o), 32'd0);
    check("rst_level", 32'(irq_clic_level_o), 32'd0);
    check("rst_priv", 32'(irq_clic_priv_o), 32'd3);
    check("rst_mnxti_pend", 32'(mnxti_irq_pending_o), 32'd0);
    rst = 1'b0;
    tick();

    // Level 0x41 normalises to 0x5F > 0x40: request one cycle later.
    present(5'd5, 8'h41);
    push_req(cyc + 1, 5'd5, 8'h5F);
    #1;
    check("wu_level_41", 32'(irq_wu_ctrl_o), 32'd1);
    tick();
    check("norm_41", 32'(irq_clic_level_o), 32'h5F);
    check("mnxti_pend_41", 32'(mnxti_irq_pending_o), 32'd1);
    check("mnxti_id_41", 32'(mnxti_irq_id_o), 32'd5);
    release_irq();

    // Level 0x20 normalises to 0x3F: below threshold, never requested.
    present(5'd6, 8'h20);
    #1;
    check("wu_level_20", 32'(irq_wu_ctrl_o), 32'd0);
    tick();
    check("norm_20", 32'(irq_clic_level_o), 32'h3F);
    tick();
    check("no_req_20", 32'(irq_req_ctrl_o), 32'd0);
    release_irq();

    // mil equal to the level blocks; lowering it releases the request at once.
    mintstatus_i.mil = 8'h5F;
    present(5'd8, 8'h41);
    repeat (3) tick();
    check("no_req_mil_eq", 32'(irq_req_ctrl_o), 32'd0);
    push_req(cyc, 5'd8, 8'h5F);
    mintstatus_i.mil = 8'h5E;
    #1;
    check("req_mil_below", 32'(irq_req_ctrl_o), 32'd1);
    mintstatus_i.mil = 8'h00;
    release_irq();

    // Ack id 7, CLIC keeps it for 5 cycles, then moves on to id 9.
    present(5'd7, 8'h80);
    push_req(cyc + 1, 5'd7, 8'h9F);
    wait_req("req_7_timeout");
    ack_req();
    tick();
    check("wu_drop_same_id", 32'(irq_wu_ctrl_o), 32'd0);
    repeat (4) tick();
    check("no_req_drop", 32'(irq_req_ctrl_o), 32'd0);
    present(5'd9, 8'h80);
    #1;
    check("wu_drop_new_id", 32'(irq_wu_ctrl_o), 32'd1);
    push_req(cyc + 2, 5'd9, 8'h9F);
    wait_req("req_9_timeout");
    release_irq();

    // CLIC replaces id 3 by id 4; ack races a switch to id 10 and acks id 4.
    present(5'd3, 8'h80);
    push_req(cyc + 1, 5'd3, 8'h9F);
    wait_req("req_3_timeout");
    present(5'd4, 8'hC0);
    push_req(cyc + 1, 5'd4, 8'hDF);
    tick();
    check("replaced_id", 32'(irq_id_ctrl_o), 32'd4);
    present(5'd10, 8'h80);
    push_req(cyc + 4, 5'd10, 8'h9F);
    ack_req();
    wait_req("req_10_timeout");
    release_irq();

    // U-mode with mie=0: M-target level 0x01 (-> 0x1F) is still requested.
    priv_lvl_i    = PRIV_LVL_U;
    mstatus_i.mie = 1'b0;
    present(5'd2, 8'h01);
    push_req(cyc + 1, 5'd2, 8'h1F);
    wait_req("req_umode_timeout");
    check("mnxti_below_thresh", 32'(mnxti_irq_pending_o), 32'd0);
    release_irq();
    // M-mode with mie=0: masked.
    priv_lvl_i = PRIV_LVL_M;
    present(5'd2, 8'h80);
    repeat (3) tick();
    check("no_req_mie0", 32'(irq_req_ctrl_o), 32'd0);
    release_irq();
    mstatus_i.mie = 1'b1;

    // mnxti: pending against mpil boundaries and shv.
    present(5'd11, 8'h80);
    push_req(cyc + 1, 5'd11, 8'h9F);
    wait_req("req_11_timeout");
    check("mnxti_pend", 32'(mnxti_irq_pending_o), 32'd1);
    check("mnxti_id", 32'(mnxti_irq_id_o), 32'd11);
    check("mnxti_level", 32'(mnxti_irq_level_o), 32'h9F);
    mcause_i.mpil = 8'h9F;
    #1;
    check("mnxti_mpil_eq", 32'(mnxti_irq_pending_o), 32'd0);
    mcause_i.mpil = 8'h9E;
    #1;
    check("mnxti_mpil_below", 32'(mnxti_irq_pending_o), 32'd1);
    mcause_i.mpil  = 8'h00;
    clic_irq_shv_i = 1'b1;
    tick();
    check("shv_captured", 32'(irq_clic_shv_o), 32'd1);
    check("mnxti_shv", 32'(mnxti_irq_pending_o), 32'd0);
    clic_irq_shv_i = 1'b0;
    release_irq();

`ifdef CV32E40S_CLIC_UMODE_IRQ_EN
    // U-target in U-mode against uintthresh=0x3F.
    priv_lvl_i      = PRIV_LVL_U;
    uintthresh_th_i = 8'h3F;
    clic_irq_priv_i = 2'b00;
    present(5'd13, 8'h30);
    repeat (3) tick();
    check("no_req_u_eq", 32'(irq_req_ctrl_o), 32'd0);
    present(5'd13, 8'h40);
    push_req(cyc + 1, 5'd13, 8'h5F);
    wait_req("req_u_timeout");
    check("priv_u", 32'(irq_clic_priv_o), 32'd0);
    release_irq();
    priv_lvl_i      = PRIV_LVL_M;
    clic_irq_priv_i = 2'b11;
`endif

    // Reset during ACK drops the pulse immediately and leaves no request.
    present(5'd12, 8'h80);
    push_req(cyc + 1, 5'd12, 8'h9F);
    wait_req("req_12_timeout");
    irq_ack_i = 1'b1;
    tick();
    check("ack_before_rst", 32'(clic_irq_ack_o), 32'd1);
    check("ack_id_before_rst", 32'(clic_irq_ack_id_o), 32'd12);
    irq_ack_i  = 1'b0;
    clic_irq_i = 1'b0;
    rst        = 1'b1;
    #1;
    check("rst_in_ack", 32'(clic_irq_ack_o), 32'd0);
    check("rst_in_ack_priv", 32'(irq_clic_priv_o), 32'd3);
    check("rst_in_ack_id", 32'(irq_id_ctrl_o), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("no_req_after_rst", 32'(irq_req_ctrl_o), 32'd0);

    repeat (3) tick();
    check("req_queue_empty", 32'(exp_req_q.size()), 32'd0);
    check("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
